// File: rtl/sigmoid_horner_seq_if.sv
// -----------------------------------------------------------------------------
// sigmoid_horner_seq_if
// Handshake and coefficient-lookup bundle for the sigmoid evaluator.
//
//   in_valid / in_ready / x_in      : pre-activation input stream (Q5.10)
//   seg_idx                         : segment index driven to the lookups
//   term1 / term2 / term3           : per-segment coefficients (Q5.10)
//   out_valid / out_ready / y_out   : activation result stream (Q5.10)
//
// Modports:
//   master : the environment (upstream source, coefficient tables, sink)
//   slave  : the evaluator itself
// -----------------------------------------------------------------------------
interface sigmoid_horner_seq_if #(
   parameter int W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic signed [W-1:0]   x_in;
   logic        [2:0]     seg_idx;
   logic signed [W-1:0]   term1;
   logic signed [W-1:0]   term2;
   logic signed [W-1:0]   term3;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [W-1:0]   y_out;

   modport master (
      output in_valid, x_in, term1, term2, term3, out_ready,
      input  in_ready, seg_idx, out_valid, y_out
   );

   modport slave (
      input  in_valid, x_in, term1, term2, term3, out_ready,
      output in_ready, seg_idx, out_valid, y_out
   );
endinterface

// File: rtl/sigmoid_horner_seq.sv
// -----------------------------------------------------------------------------
// sigmoid_horner_seq
// Sequential piecewise-quadratic sigmoid for the neuron activation path.
// |x| selects a segment; the segment's coefficients come back combinationally
// and y = t1 + t2*d + t3*d^2 is evaluated by Horner's rule on one shared
// multiplier. Negative inputs use odd symmetry: y(-x) = 1 - y(x).
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, returns the FSM to IDLE
//   bus  : sigmoid_horner_seq_if.slave
//          in_valid/in_ready/x_in     input handshake (ready only in IDLE)
//          seg_idx                    registered segment index to lookups
//          term1/term2/term3          coefficients for seg_idx
//          out_valid/out_ready/y_out  output handshake, held until taken
//
// Build option:
//   SIGMOID_HORNER_ROUND_EN  defined   : products round half up before >>> FRAC
//                            undefined : products truncate toward -inf
//
// Sequence: IDLE -> SEG -> MAC1 -> MAC2 -> SIGN -> HOLD -> IDLE.
// out_valid is first seen 4 cycles after the accept edge; with out_ready tied
// high a new result is produced every 6 cycles.
// -----------------------------------------------------------------------------
module sigmoid_horner_seq #(
   parameter int           W    = 16,
   parameter int           FRAC = 10,
   parameter logic [W-1:0] ONE  = 16'h0400
) (
   input  logic                 clk,
   input  logic                 rst,
   sigmoid_horner_seq_if.slave  bus
);

   // integer-part width of |x| (Q5.10 -> 5 bits)
   localparam int IPW = W - 1 - FRAC;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SEG  = 3'd1;
   localparam logic [2:0] S_MAC1 = 3'd2;
   localparam logic [2:0] S_MAC2 = 3'd3;
   localparam logic [2:0] S_SIGN = 3'd4;
   localparam logic [2:0] S_HOLD = 3'd5;

   localparam logic [2:0]           SEG_SAT = 3'd6;
   localparam logic [IPW-1:0]       IP_4    = IPW'(4);
   localparam logic [IPW-1:0]       IP_5    = IPW'(5);
   localparam logic signed [W-1:0]  S_MAX   = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]  S_MIN   = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [2*W:0]  HALF    = (2*W+1)'(1) << (FRAC - 1);

   // --------------------------------------------------------------------------
   // Arithmetic helpers
   // --------------------------------------------------------------------------

   // Product -> Q5.10: optional half-up rounding, arithmetic shift, then clamp.
   function automatic logic signed [W-1:0] scale_sat(input logic signed [2*W:0] p);
      logic signed [2*W:0] t;
      t = p;
`ifdef SIGMOID_HORNER_ROUND_EN
      t = t + HALF;
`endif
      t = t >>> FRAC;
      // fits in W bits when every bit above the sign bit matches it
      if ((t[2*W:W-1] == '0) || (t[2*W:W-1] == '1))
         return t[W-1:0];
      else
         return t[2*W] ? S_MIN : S_MAX;
   endfunction

   function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
      logic signed [W:0] s;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1])
         return s[W] ? S_MIN : S_MAX;
      else
         return s[W-1:0];
   endfunction

   function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
      logic signed [W:0] s;
      s = {a[W-1], a} - {b[W-1], b};
      if (s[W] != s[W-1])
         return s[W] ? S_MIN : S_MAX;
      else
         return s[W-1:0];
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [2:0]           r_state;
   logic signed [W-1:0]  r_x;
   logic                 r_neg;
   logic [W-1:0]         r_d;
   logic signed [W-1:0]  r_acc;
   logic [2:0]           r_seg;
   logic signed [W-1:0]  r_y;
   logic                 r_out_valid;

   // --------------------------------------------------------------------------
   // Segment classification (consumed in SEG from the latched input)
   // --------------------------------------------------------------------------
   logic [W-1:0]    w_abs;
   logic [IPW-1:0]  w_ip;
   logic [IPW-1:0]  w_base;
   logic [2:0]      w_seg;
   logic [W-1:0]    w_d;

   always_comb begin
      // -32768 has no positive twin; clamp its magnitude to the largest value
      if (!r_x[W-1])
         w_abs = r_x;
      else if (r_x == S_MIN)
         w_abs = S_MAX;
      else
         w_abs = -r_x;

      w_ip = w_abs[W-2:FRAC];

      if (w_ip < IP_4)
         w_seg = w_ip[2:0];
      else if (w_ip == IP_4)
         w_seg = 3'd4;
      else if (w_ip == IP_5)
         w_seg = 3'd5;
      else
         w_seg = SEG_SAT;

      w_base = (w_ip < IP_4) ? w_ip : IP_4;

      // abs - (base << FRAC): the fraction is untouched, only the integer part
      // is reduced, so the offset is assembled directly. Segment 5 keeps a
      // leading 1 here (1.0 <= d < 2.0); segment 6 ignores d.
      w_d = {1'b0, w_ip - w_base, w_abs[FRAC-1:0]};
   end

   // --------------------------------------------------------------------------
   // Shared multiplier: term3*d in MAC1, acc*d in MAC2
   // --------------------------------------------------------------------------
   logic signed [W-1:0]   w_mul_a;
   logic signed [W:0]     w_mul_b;
   logic signed [2*W:0]   w_prod;
   logic signed [W-1:0]   w_scaled;
   logic signed [W-1:0]   w_add_term;
   logic signed [W-1:0]   w_mac;

   always_comb begin
      w_mul_a    = (r_state == S_MAC1) ? bus.term3 : r_acc;
      w_add_term = (r_state == S_MAC1) ? bus.term2 : bus.term1;
      // d is unsigned; a zero top bit keeps it positive in the signed product
      w_mul_b    = {1'b0, r_d};
      w_prod     = w_mul_a * w_mul_b;
      w_scaled   = scale_sat(w_prod);
      w_mac      = sat_add(w_scaled, w_add_term);
   end

   // --------------------------------------------------------------------------
   // Control and datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_neg       <= 1'b0;
         r_d         <= '0;
         r_acc       <= '0;
         r_seg       <= 3'd0;
         r_y         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_x     <= bus.x_in;
                  r_state <= S_SEG;
               end
            end

            S_SEG: begin
               r_neg   <= r_x[W-1];
               r_d     <= w_d;
               r_seg   <= w_seg;
               r_state <= S_MAC1;
            end

            // saturated segment: sigmoid is 1.0; MAC states still take a cycle
            S_MAC1: begin
               r_acc   <= (r_seg == SEG_SAT) ? ONE : w_mac;
               r_state <= S_MAC2;
            end

            S_MAC2: begin
               r_acc   <= (r_seg == SEG_SAT) ? ONE : w_mac;
               r_state <= S_SIGN;
            end

            S_SIGN: begin
               r_y         <= r_neg ? sat_sub(ONE, r_acc) : r_acc;
               r_out_valid <= 1'b1;
               r_state     <= S_HOLD;
            end

            S_HOLD: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.seg_idx   = r_seg;
   assign bus.out_valid = r_out_valid;
   assign bus.y_out     = r_y;

endmodule

// File: tb/tb_sigmoid_horner_seq.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_horner_seq
// Directed bench for sigmoid_horner_seq. A small coefficient table answers
// seg_idx; expected segment/result pairs are queued when an input is driven
// and popped when the result appears.
// -----------------------------------------------------------------------------
module tb_sigmoid_horner_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_y_q [$];
   logic [15:0] exp_s_q [$];

   sigmoid_horner_seq_if #(.W(16)) bus ();

   sigmoid_horner_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Coefficient lookup model. Segment 6 carries junk to expose a missing bypass.
   always_comb begin
      bus.term1 = 16'h0000;
      bus.term2 = 16'h0000;
      bus.term3 = 16'h0000;
      case (bus.seg_idx)
         3'd0: begin bus.term1 = 16'h0200; bus.term2 = 16'h0001; bus.term3 = 16'h0000; end
         3'd1: begin bus.term1 = 16'h0345; bus.term2 = 16'h0000; bus.term3 = 16'h0000; end
         3'd2: begin bus.term1 = 16'h0100; bus.term2 = 16'h0000; bus.term3 = 16'hFF00; end
         3'd3: begin bus.term1 = 16'h7F00; bus.term2 = 16'h7000; bus.term3 = 16'h7000; end
         3'd4: begin bus.term1 = 16'h8000; bus.term2 = 16'h0000; bus.term3 = 16'h0000; end
         3'd5: begin bus.term1 = 16'h0300; bus.term2 = 16'h0100; bus.term3 = 16'h0080; end
         3'd6: begin bus.term1 = 16'h1234; bus.term2 = 16'h5555; bus.term3 = 16'h6666; end
         default: begin bus.term1 = 16'h0000; bus.term2 = 16'h0000; bus.term3 = 16'h0000; end
      endcase
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one input, wait for its result, compare, optionally stall the sink
   // for hold_cyc cycles (with a competing in_valid when poke=1), then drain.
   task automatic run_txn(input string tag, input logic [15:0] x,
                          input logic [15:0] e_seg, input logic [15:0] e_y,
                          input int hold_cyc, input bit poke);
      int lat;
      logic [15:0] ey;
      logic [15:0] es;
      exp_y_q.push_back(e_y);
      exp_s_q.push_back(e_seg);

      @(negedge clk);
      check({tag, "_in_ready"}, 16'(bus.in_ready), 16'h0001);
      bus.in_valid = 1'b1;
      bus.x_in     = x;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;

      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"}, 16'(lat), 16'd4);

      ey = exp_y_q.pop_front();
      es = exp_s_q.pop_front();
      check({tag, "_seg"}, 16'(bus.seg_idx), es);
      check({tag, "_y"}, bus.y_out, ey);

      if (poke) begin
         bus.in_valid = 1'b1;
         bus.x_in     = 16'h1C00;
      end
      for (int i = 0; i < hold_cyc; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "_hold_y"}, bus.y_out, ey);
         check({tag, "_hold_valid"}, 16'(bus.out_valid), 16'h0001);
         check({tag, "_hold_in_ready"}, 16'(bus.in_ready), 16'h0000);
      end

      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check({tag, "_drain_valid"}, 16'(bus.out_valid), 16'h0000);
      // in_ready high here also proves no input was taken on the handshake edge
      check({tag, "_drain_in_ready"}, 16'(bus.in_ready), 16'h0001);
   endtask

   initial begin
      int spurious;
      bus.in_valid  = 1'b0;
      bus.x_in      = 16'h0000;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 16'(bus.in_ready), 16'h0001);
      check("rst_out_valid", 16'(bus.out_valid), 16'h0000);
      check("rst_y", bus.y_out, 16'h0000);
      check("rst_seg", 16'(bus.seg_idx), 16'h0000);

      run_txn("zero",      16'h0000, 16'd0, 16'h0200, 0, 1'b0);
      run_txn("pos_seg1",  16'h0400, 16'd1, 16'h0345, 0, 1'b0);
      run_txn("neg_seg1",  16'hFC00, 16'd1, 16'h00BB, 0, 1'b0);
      run_txn("sat_7p0",   16'h1C00, 16'd6, 16'h0400, 0, 1'b0);
      run_txn("sat_min",   16'h8000, 16'd6, 16'h0000, 0, 1'b0);
      run_txn("seg6_edge", 16'h1800, 16'd6, 16'h0400, 0, 1'b0);
`ifdef SIGMOID_HORNER_ROUND_EN
      run_txn("horner_half", 16'h0200, 16'd0, 16'h0201, 0, 1'b0);
      run_txn("neg_coef",    16'h0A81, 16'd2, 16'h009C, 0, 1'b0);
`else
      run_txn("horner_half", 16'h0200, 16'd0, 16'h0200, 0, 1'b0);
      run_txn("neg_coef",    16'h0A81, 16'd2, 16'h009B, 0, 1'b0);
`endif
      run_txn("seg5_5p0",  16'h1400, 16'd5, 16'h0480, 0, 1'b0);
      run_txn("seg5_5p5",  16'h1600, 16'd5, 16'h05A0, 0, 1'b0);
      run_txn("seg5_neg",  16'hEA00, 16'd5, 16'hFE60, 0, 1'b0);
      run_txn("mac_sat",   16'h0FFF, 16'd3, 16'h7FFF, 0, 1'b0);
      run_txn("sign_sat",  16'hF000, 16'd4, 16'h7FFF, 0, 1'b0);
      run_txn("backpress", 16'h0400, 16'd1, 16'h0345, 10, 1'b1);

      // Reset while the FSM sits in MAC1
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_in     = 16'h0400;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_out_valid", 16'(bus.out_valid), 16'h0000);
      check("midrst_in_ready", 16'(bus.in_ready), 16'h0001);
      check("midrst_seg", 16'(bus.seg_idx), 16'h0000);
      spurious = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid !== 1'b0) spurious++;
      end
      check("midrst_no_output", 16'(spurious), 16'h0000);

      run_txn("after_rst", 16'hFC00, 16'd1, 16'h00BB, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
